// File: rtl/dct_pkg.sv
// Shared definitions for the fdct_zigzag DCT datapath.
//   DCT_N           : terms per 1-D DCT output
//   DCT_PROD_W      : default signed product width
//   DCT_OUT_W       : default signed coefficient width
//   DCT_RND_SHIFT   : default fractional bits removed by rounding
//   dct_coef_t      : coefficient type at the default width
//   dct_slot_t      : output-slot occupancy state
package dct_pkg;

    localparam int DCT_N         = 8;
    localparam int DCT_PROD_W    = 24;
    localparam int DCT_OUT_W     = 12;
    localparam int DCT_RND_SHIFT = 11;

    typedef logic signed [DCT_OUT_W-1:0] dct_coef_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } dct_slot_t;

endpackage

// File: rtl/dct_round_sat.sv
// Combinational round-half-up and saturate of a signed accumulator sum.
//   sum : ACC_W signed sum
//   res : OUT_W signed result, (sum + 2^(RND_SHIFT-1)) >>> RND_SHIFT, clipped
//   sat : result was clipped
module dct_round_sat #(
    parameter int ACC_W     = 27,
    parameter int OUT_W     = 12,
    parameter int RND_SHIFT = 11
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] res,
    output logic                    sat
);

    // One extra bit so adding the rounding half cannot wrap at the positive limit.
    localparam int RW = ACC_W + 1 - RND_SHIFT;
    localparam logic signed [RW-1:0] R_MAX = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] R_MIN = ~R_MAX;

    logic signed [ACC_W:0]  half;
    logic signed [ACC_W:0]  biased;
    logic signed [RW-1:0]   r;

    always_comb begin
        half               = '0;
        half[RND_SHIFT-1]  = 1'b1;
        biased             = $signed({sum[ACC_W-1], sum}) + half;
        r                  = biased[ACC_W:RND_SHIFT];
        res                = r[OUT_W-1:0];
        sat                = 1'b0;
        if (r > R_MAX) begin
            res = R_MAX[OUT_W-1:0];
            sat = 1'b1;
        end else if (r < R_MIN) begin
            res = R_MIN[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/dct_coef_accum.sv
// DCT MAC accumulation stage: sums eight signed products per output term,
// rounds/saturates the total and offers it on a valid/ready slot.
//   clk, rst_n (sync, active-low), ena (global clock enable)
//   prod_valid/prod_first/prod/prod_ready : product input handshake
//   coef_valid/coef_ready/coef/coef_sat   : coefficient output handshake
//   seq_err                               : one-cycle framing-violation pulse
module dct_coef_accum
    import dct_pkg::*;
#(
    parameter int PROD_W    = DCT_PROD_W,
    parameter int ACC_W     = PROD_W + 3,
    parameter int OUT_W     = DCT_OUT_W,
    parameter int RND_SHIFT = DCT_RND_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     prod_valid,
    input  logic                     prod_first,
    input  logic signed [PROD_W-1:0] prod,
    output logic                     prod_ready,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic signed [OUT_W-1:0]  coef,
    output logic                     coef_sat,
    output logic                     seq_err
);

    localparam logic [2:0] LAST = 3'(DCT_N - 1);

    dct_slot_t               slot;
    logic [2:0]              cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum_full;
    logic signed [OUT_W-1:0] rs_res;
    logic                    rs_sat;
    logic                    prod_acc;
    logic                    restart;
    logic                    complete;
    logic                    frame_bad;

    assign coef_valid = (slot == SLOT_FULL);
    assign prod_ready = !((cnt == LAST) && coef_valid && !coef_ready);

    assign prod_ext  = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign sum_full  = acc + prod_ext;
    assign prod_acc  = prod_valid && prod_ready && ena;
    assign restart   = prod_acc && prod_first && (cnt != '0);
    assign complete  = prod_acc && !restart && (cnt == LAST);
    assign frame_bad = prod_acc && (prod_first ? (cnt != '0) : (cnt == '0));

    dct_round_sat #(
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .RND_SHIFT (RND_SHIFT)
    ) u_round_sat (
        .sum (sum_full),
        .res (rs_res),
        .sat (rs_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            slot     <= SLOT_EMPTY;
            coef     <= '0;
            coef_sat <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (ena) begin
                seq_err <= frame_bad;
                if (prod_acc) begin
                    if (restart) begin
                        acc <= prod_ext;
                        cnt <= 3'd1;
                    end else begin
                        acc <= (cnt == '0) ? prod_ext : sum_full;
                        cnt <= cnt + 3'd1;
                    end
                end
                // A completion always (re)loads the slot, so a same-cycle
                // consume-and-load leaves it FULL with the new value.
                unique case (slot)
                    SLOT_EMPTY: begin
                        if (complete) begin
                            slot     <= SLOT_FULL;
                            coef     <= rs_res;
                            coef_sat <= rs_sat;
                        end
                    end
                    SLOT_FULL: begin
                        if (complete) begin
                            coef     <= rs_res;
                            coef_sat <= rs_sat;
                        end else if (coef_ready) begin
                            slot <= SLOT_EMPTY;
                        end
                    end
                    default: slot <= SLOT_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: doc/dct_coef_accum.md
# dct_coef_accum

Accumulation stage of a DCT unit's MAC in the JPEG encoder's fdct_zigzag datapath. It sits directly downstream of the registered multiplier result (`mult_res`). It sums the eight signed products of one 1-D DCT output term, rounds and saturates the sum to a coefficient, and presents the coefficient on a valid/ready interface to the dct_block collector. It replaces the free-running `dclr`-cleared accumulator with an explicit term count, back-pressure and sequence-error detection.

## Interface
- PROD_W, 24: signed product width (8-bit sample × 16-bit cosine coefficient).
- ACC_W, PROD_W+3: accumulator width; guarantees no overflow over 8 terms.
- OUT_W, 12: signed coefficient width.
- RND_SHIFT, 11: fractional bits removed by rounding.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- ena, input, 1: global clock enable; when low, all state holds.
- prod_valid, input, 1: `prod` and `prod_first` are valid.
- prod_first, input, 1: marks term 0 of a new 8-term sum.
- prod, input, PROD_W: signed product from `mult_res`.
- prod_ready, output, 1: product is accepted when `prod_valid & prod_ready & ena`.
- coef_valid, output, 1: `coef` and `coef_sat` are valid.
- coef_ready, input, 1: consumer accepts when `coef_valid & coef_ready & ena`.
- coef, output, OUT_W: rounded, saturated signed coefficient.
- coef_sat, output, 1: `coef` was clipped.
- seq_err, output, 1: one-cycle pulse on a framing violation.

## Operation
- Term counter `cnt` (3 bits, 0..7). On an accepted product:
  - If `cnt==0`: `acc <= sext(prod)`.
  - Otherwise: `acc <= acc + sext(prod)`.
  - Then `cnt <= cnt+1`, wrapping 7→0.
- Framing:
  - `prod_first=1` with `cnt!=0` discards the partial sum, loads `acc <= sext(prod)`, sets `cnt <= 1`, and pulses `seq_err`.
  - `prod_first=0` with `cnt==0` is accepted normally and pulses `seq_err`.
- Completion: on the accepted product with `cnt==7`:
  - Form `s = acc + sext(prod)`.
  - Round half-up: `r = (s + 2^(RND_SHIFT-1)) >>> RND_SHIFT`, arithmetic shift.
  - Saturate `r` to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Load `coef` and `coef_sat`, and set `coef_valid`.
- Output slot (two states, EMPTY/FULL):
  - EMPTY→FULL on completion.
  - FULL→EMPTY on a consumer accept with no simultaneous completion.
  - FULL→FULL when both occur in the same cycle: the old coefficient is consumed and the new one is loaded.
- Back-pressure: `prod_ready = !(cnt==7 && coef_valid && !coef_ready)`. Terms 0..6 of the next sum are always accepted while the slot is FULL.
- `ena=0`: `cnt`, `acc` and the output slot hold, `seq_err` is 0, and no handshake completes.
- Reset values: `cnt=0`, `acc=0`, `coef_valid=0`, `coef=0`, `coef_sat=0`, `seq_err=0`.
- Reset mid-sum discards the partial sum and any pending coefficient.

## Timing
- Latency: the 8th term is accepted at edge k, and `coef_valid` is high after edge k (one cycle). There is no extra pipeline register.
- Throughput: one coefficient per 8 accepted products, with no bubbles when `coef_ready` stays high.
- `prod_ready` is combinational from `cnt`, `coef_valid` and `coef_ready` only. There is no path from `prod_valid`.
- `coef`, `coef_sat` and `coef_valid` are registered outputs.
- `seq_err` is registered and high for exactly one cycle.

## Structure
- Shared package `dct_pkg` holds:
  - `DCT_N=8`;
  - default PROD_W, OUT_W and RND_SHIFT;
  - `typedef logic signed [OUT_W-1:0] dct_coef_t`.
- Sub-module `dct_round_sat` is purely combinational. It takes an ACC_W sum and returns the OUT_W result plus the sat flag. It is reused by the zigzag/quantiser stage.
- The top level holds the counter, accumulator, output slot and framing check.

## Test plan
- Eight products of 1024, `prod_first` on term 0, `coef_ready=1` → `coef=4`, `coef_sat=0`. `coef_valid` is high for one cycle, one cycle after term 8.
- Rounding at the half boundary:
  - Terms {-1024, 0×7} → `coef=0`.
  - Terms {-1025, 0×7} → `coef=-1`.
  - Terms {1023, 0×7} → `coef=0`.
- Saturation:
  - Eight products of 4194303 → `coef=2047`, `coef_sat=1`.
  - Eight products of -8388608 → `coef=-2048`, `coef_sat=1`.
- Back-pressure:
  - Hold `coef_ready=0` and stream 16 products of 1024 → the first `coef=4` is held. `prod_ready` drops only while `cnt==7`.
  - Raise `coef_ready` → the held coefficient is consumed and the 16th term is accepted on the same edge. The second `coef=4` appears the next cycle.
- Framing error: assert `prod_first` on term 4 → `seq_err` pulses once, the partial sum is discarded, and the next coefficient equals the sum of the 8 terms starting at the restart.
- Reset and enable:
  - Drive `rst_n=0` for one cycle after 5 terms, then feed 8×1024 → `coef=4`. All outputs read their reset values during reset.
  - Toggle `ena` low mid-sum → the result is unchanged.
